// File: rtl/rrf_pkg.sv
// rtl/rrf_pkg.sv - shared RRF sizing constants, tag/count types and request clamp
package rrf_pkg;
  localparam int RRF_DEPTH = 16;
  localparam int TAG_W     = 4;

  typedef logic [TAG_W-1:0] rrf_tag_t;
  typedef logic [TAG_W:0]   rrf_cnt_t;

  // Dispatch and commit move at most two slots per cycle; a request of 3 means 2.
  function automatic logic [1:0] clamp_two(input logic [1:0] n);
    return (n == 2'd3) ? 2'd2 : n;
  endfunction
endpackage

// File: rtl/rrf_ptr_adv.sv
// rtl/rrf_ptr_adv.sv - modulo RRF_DEPTH pointer advance by 0..2 slots
module rrf_ptr_adv
  import rrf_pkg::*;
(
  input  rrf_tag_t   i_ptr,
  input  logic [1:0] i_step,
  output rrf_tag_t   o_ptr_nxt
);
  // Tag width equals log2(depth), so natural overflow gives the wrap 15 -> 0.
  assign o_ptr_nxt = i_ptr + rrf_tag_t'(i_step);
endmodule

// File: rtl/rrf_alloc_ctrl.sv
// rtl/rrf_alloc_ctrl.sv - RRF tag allocation, writeback tracking and in-order retirement
// RRF_FREE_BYPASS_EN lets entries retired this cycle be reallocated in the same cycle.
module rrf_alloc_ctrl
  import rrf_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic [1:0]           i_alloc_cnt,
  output logic                 o_alloc_grant,
  output rrf_tag_t             o_alloc_tag0,
  output rrf_tag_t             o_alloc_tag1,
  input  logic                 i_wb_en,
  input  rrf_tag_t             i_wb_tag,
  output logic [1:0]           o_commit_avail,
  input  logic [1:0]           i_commit_cnt,
  output rrf_tag_t             o_commit_tag0,
  output rrf_tag_t             o_commit_tag1,
  output logic [RRF_DEPTH-1:0] o_busy_vec,
  output logic [RRF_DEPTH-1:0] o_valid_vec,
  output rrf_cnt_t             o_free_cnt,
  output logic                 o_full
);
  rrf_tag_t             r_head;
  rrf_tag_t             r_tail;
  rrf_cnt_t             r_count;
  logic [RRF_DEPTH-1:0] r_busy;
  logic [RRF_DEPTH-1:0] r_valid;

  logic [1:0]           w_alloc_n;
  logic [1:0]           w_eff;
  logic [1:0]           w_head_step;
  logic                 w_live0;
  logic                 w_live1;
  rrf_cnt_t             w_avail_free;
  rrf_tag_t             w_head_p1;
  rrf_tag_t             w_tail_p1;
  rrf_tag_t             w_head_nxt;
  rrf_tag_t             w_tail_nxt;
  logic [RRF_DEPTH-1:0] w_busy_nxt;
  logic [RRF_DEPTH-1:0] w_valid_nxt;

  rrf_ptr_adv u_head_adv (
    .i_ptr     (r_head),
    .i_step    (w_head_step),
    .o_ptr_nxt (w_head_nxt)
  );

  rrf_ptr_adv u_tail_adv (
    .i_ptr     (r_tail),
    .i_step    (w_eff),
    .o_ptr_nxt (w_tail_nxt)
  );

  assign w_head_p1 = r_head + rrf_tag_t'(1);
  assign w_tail_p1 = r_tail + rrf_tag_t'(1);
  assign w_alloc_n = clamp_two(i_alloc_cnt);

  // Only allocated entries are busy, so a busy&valid check at tail+1 never reaches past head.
  assign w_live0        = r_busy[r_tail] & r_valid[r_tail];
  assign w_live1        = r_busy[w_tail_p1] & r_valid[w_tail_p1];
  assign o_commit_avail = !w_live0 ? 2'd0 : (w_live1 ? 2'd2 : 2'd1);
  assign w_eff          = (i_commit_cnt < o_commit_avail) ? i_commit_cnt : o_commit_avail;

  assign o_free_cnt = rrf_cnt_t'(RRF_DEPTH) - r_count;
  assign o_full     = (r_count == rrf_cnt_t'(RRF_DEPTH));

`ifdef RRF_FREE_BYPASS_EN
  assign w_avail_free = o_free_cnt + rrf_cnt_t'(w_eff);
`else
  assign w_avail_free = o_free_cnt;
`endif

  assign o_alloc_grant = (rrf_cnt_t'(w_alloc_n) <= w_avail_free);
  assign w_head_step   = o_alloc_grant ? w_alloc_n : 2'd0;

  assign o_alloc_tag0  = r_head;
  assign o_alloc_tag1  = w_head_p1;
  assign o_commit_tag0 = r_tail;
  assign o_commit_tag1 = w_tail_p1;
  assign o_busy_vec    = r_busy;
  assign o_valid_vec   = r_valid;

  // Ordering makes allocation the last writer, so a bypass-reallocated or wb-collided entry ends busy, not valid.
  always_comb begin
    w_busy_nxt  = r_busy;
    w_valid_nxt = r_valid;
    if (i_wb_en && r_busy[i_wb_tag]) begin
      w_valid_nxt[i_wb_tag] = 1'b1;
    end
    if (w_eff != 2'd0) begin
      w_busy_nxt[r_tail]  = 1'b0;
      w_valid_nxt[r_tail] = 1'b0;
    end
    if (w_eff == 2'd2) begin
      w_busy_nxt[w_tail_p1]  = 1'b0;
      w_valid_nxt[w_tail_p1] = 1'b0;
    end
    if (w_head_step != 2'd0) begin
      w_busy_nxt[r_head]  = 1'b1;
      w_valid_nxt[r_head] = 1'b0;
    end
    if (w_head_step == 2'd2) begin
      w_busy_nxt[w_head_p1]  = 1'b1;
      w_valid_nxt[w_head_p1] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
      r_valid <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
      r_valid <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= r_count + rrf_cnt_t'(w_head_step) - rrf_cnt_t'(w_eff);
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
    end
  end
endmodule
